nucleic_acid_sequencer: RTL

Protocol sequencer for the nucleic-acid reactor array. It drives every shared pneumatic control line of the array (reagent selects, routing valves, bead trap, collection/waste, 3-valve peristaltic pump) through a fixed load → mix → trap → wash → elute → collect run. All reactor instances share these lines, so one sequencer runs all reactors in lockstep. Every step is separated by an all-closed settle gap.

---
 rtl/nucleic_acid_sequencer_if.sv | 42 ++++
 rtl/nucleic_acid_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nucleic_acid_sequencer_if.sv
// Control bundle between the reactor-array host and the protocol sequencer:
// run requests in, status and every shared pneumatic line out.
interface nucleic_acid_sequencer_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] step;
  logic       lysis_ctl;
  logic       wash_ctl;
  logic       elute_ctl;
  logic       horiz_ctl;
  logic       vertical_ctl;
  logic       loop_exit_ctl;
  logic       bead_vtl_ctl;
  logic       bead_trap_ctl;
  logic       collection_ctl;
  logic       waste_ctl;
  logic       dead_end_ctl;
  logic       pump1;
  logic       pump2;
  logic       pump3;

  // Host side: issues requests, observes status and valve lines
  modport master (
    output start, abort,
    input  busy, done, aborted, step,
    input  lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
    input  loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl,
    input  waste_ctl, dead_end_ctl, pump1, pump2, pump3
  );

  // Sequencer side: takes requests, drives status and valve lines
  modport slave (
    input  start, abort,
    output busy, done, aborted, step,
    output lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
    output loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl,
    output waste_ctl, dead_end_ctl, pump1, pump2, pump3
  );
endinterface

// File: rtl/nucleic_acid_sequencer.sv
// Protocol sequencer for the nucleic-acid reactor array. Steps all shared
// pneumatic lines through load -> mix -> trap -> wash -> elute -> collect,
// with an all-closed settle gap between steps. Valve outputs are active
// high (1 = pressurized = closed) and all outputs are registered.
module nucleic_acid_sequencer #(
  parameter int LOAD_TICKS    = 64,
  parameter int TRAP_TICKS    = 64,
  parameter int WASH_TICKS    = 128,
  parameter int ELUTE_TICKS   = 64,
  parameter int COLLECT_TICKS = 64,
  parameter int SETTLE_TICKS  = 8,
  parameter int PUMP_DIV      = 16,
  parameter int MIX_REVS      = 32,
  parameter int TICK_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nucleic_acid_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_MIX     = 4'd2,
    S_TRAP    = 4'd3,
    S_WASH    = 4'd4,
    S_ELUTE   = 4'd5,
    S_COLLECT = 4'd6,
    S_DONE    = 4'd7,
    S_GAP     = 4'd8
  } state_t;

  localparam logic [TICK_W-1:0] W_ONE     = TICK_W'(1);
  localparam logic [TICK_W-1:0] T_LOAD    = TICK_W'(LOAD_TICKS);
  localparam logic [TICK_W-1:0] T_TRAP    = TICK_W'(TRAP_TICKS);
  localparam logic [TICK_W-1:0] T_WASH    = TICK_W'(WASH_TICKS);
  localparam logic [TICK_W-1:0] T_ELUTE   = TICK_W'(ELUTE_TICKS);
  localparam logic [TICK_W-1:0] T_COLLECT = TICK_W'(COLLECT_TICKS);
  localparam logic [TICK_W-1:0] T_SETTLE  = TICK_W'(SETTLE_TICKS);
  localparam logic [TICK_W-1:0] T_PUMP    = TICK_W'(PUMP_DIV);
  localparam logic [TICK_W-1:0] T_REVS    = TICK_W'(MIX_REVS);

  // Bit positions inside the 11-valve field (pumps follow as the low 3 bits)
  localparam int V_LYSIS      = 10;
  localparam int V_WASH       = 9;
  localparam int V_ELUTE      = 8;
  localparam int V_HORIZ      = 7;
  localparam int V_VERTICAL   = 6;
  localparam int V_LOOP_EXIT  = 5;
  localparam int V_BEAD_TRAP  = 3;
  localparam int V_COLLECTION = 2;
  localparam int V_WASTE      = 1;

  localparam logic [13:0] ALL_CLOSED = 14'h3FFF;

  state_t            r_state;
  state_t            r_next_step;
  logic [TICK_W-1:0] r_timer;
  logic [TICK_W-1:0] r_revs;
  logic [2:0]        r_phase;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic [13:0]       r_valves;

  // Peristaltic sequence: one valve flips per phase
  function automatic logic [2:0] pump_bits(input logic [2:0] phase);
    case (phase)
      3'd0:    pump_bits = 3'b110;
      3'd1:    pump_bits = 3'b100;
      3'd2:    pump_bits = 3'b101;
      3'd3:    pump_bits = 3'b001;
      3'd4:    pump_bits = 3'b011;
      3'd5:    pump_bits = 3'b010;
      default: pump_bits = 3'b111;
    endcase
  endfunction

  // Full 14-bit line pattern for a state; bead_vtl and dead_end never open
  function automatic logic [13:0] valve_map(input state_t st, input logic [2:0] phase);
    logic [10:0] v;
    v = '1;
    case (st)
      S_LOAD: begin
        v[V_LYSIS] = 1'b0; v[V_VERTICAL] = 1'b0; v[V_HORIZ] = 1'b0;
      end
      S_TRAP: begin
        v[V_LOOP_EXIT] = 1'b0; v[V_BEAD_TRAP] = 1'b0; v[V_WASTE] = 1'b0;
      end
      S_WASH: begin
        v[V_WASH] = 1'b0; v[V_VERTICAL] = 1'b0; v[V_LOOP_EXIT] = 1'b0;
        v[V_BEAD_TRAP] = 1'b0; v[V_WASTE] = 1'b0;
      end
      S_ELUTE: begin
        v[V_ELUTE] = 1'b0; v[V_VERTICAL] = 1'b0;
      end
      S_COLLECT: begin
        v[V_LOOP_EXIT] = 1'b0; v[V_BEAD_TRAP] = 1'b0; v[V_COLLECTION] = 1'b0;
      end
      default: v = '1;
    endcase
    valve_map = {v, (st == S_MIX) ? pump_bits(phase) : 3'b111};
  endfunction

  // Dwell loaded on entry to each step; MIX reloads per pump phase
  function automatic logic [TICK_W-1:0] ticks_of(input state_t st);
    case (st)
      S_LOAD:    ticks_of = T_LOAD;
      S_MIX:     ticks_of = T_PUMP;
      S_TRAP:    ticks_of = T_TRAP;
      S_WASH:    ticks_of = T_WASH;
      S_ELUTE:   ticks_of = T_ELUTE;
      S_COLLECT: ticks_of = T_COLLECT;
      default:   ticks_of = T_SETTLE;
    endcase
  endfunction

  // Step that the settle gap hands over to
  function automatic state_t succ(input state_t st);
    case (st)
      S_LOAD:  succ = S_MIX;
      S_MIX:   succ = S_TRAP;
      S_TRAP:  succ = S_WASH;
      S_WASH:  succ = S_ELUTE;
      default: succ = S_COLLECT;
    endcase
  endfunction

  // Sequencer FSM: state, dwell timer, pump phase and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_next_step <= S_LOAD;
      r_timer     <= '0;
      r_revs      <= '0;
      r_phase     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_valves    <= ALL_CLOSED;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (r_state != S_IDLE && bus.abort) begin
        // DONE already reported completion, so no abort pulse from there
        r_state   <= S_IDLE;
        r_timer   <= '0;
        r_revs    <= '0;
        r_phase   <= '0;
        r_busy    <= 1'b0;
        r_valves  <= ALL_CLOSED;
        r_aborted <= (r_state != S_DONE);
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              r_state  <= S_LOAD;
              r_timer  <= T_LOAD;
              r_busy   <= 1'b1;
              r_valves <= valve_map(S_LOAD, 3'd0);
            end
          end
          S_LOAD, S_TRAP, S_WASH, S_ELUTE: begin
            if (r_timer == W_ONE) begin
              r_state     <= S_GAP;
              r_next_step <= succ(r_state);
              r_timer     <= T_SETTLE;
              r_valves    <= ALL_CLOSED;
            end else begin
              r_timer <= r_timer - W_ONE;
            end
          end
          S_MIX: begin
            if (r_timer != W_ONE) begin
              r_timer <= r_timer - W_ONE;
            end else if (r_phase != 3'd5) begin
              r_phase  <= r_phase + 3'd1;
              r_timer  <= T_PUMP;
              r_valves <= valve_map(S_MIX, r_phase + 3'd1);
            end else if (r_revs != T_REVS - W_ONE) begin
              r_revs   <= r_revs + W_ONE;
              r_phase  <= 3'd0;
              r_timer  <= T_PUMP;
              r_valves <= valve_map(S_MIX, 3'd0);
            end else begin
              // Last revolution complete: leave MIX with counters cleared
              r_state     <= S_GAP;
              r_next_step <= S_TRAP;
              r_revs      <= '0;
              r_phase     <= 3'd0;
              r_timer     <= T_SETTLE;
              r_valves    <= ALL_CLOSED;
            end
          end
          S_COLLECT: begin
            if (r_timer == W_ONE) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_timer  <= '0;
              r_valves <= ALL_CLOSED;
            end else begin
              r_timer <= r_timer - W_ONE;
            end
          end
          S_GAP: begin
            if (r_timer == W_ONE) begin
              r_state  <= r_next_step;
              r_timer  <= ticks_of(r_next_step);
              r_valves <= valve_map(r_next_step, 3'd0);
            end else begin
              r_timer <= r_timer - W_ONE;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_busy   <= 1'b0;
            r_valves <= ALL_CLOSED;
          end
        endcase
      end
    end
  end

  assign bus.step    = r_state;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.aborted = r_aborted;
  assign {bus.lysis_ctl, bus.wash_ctl, bus.elute_ctl, bus.horiz_ctl,
          bus.vertical_ctl, bus.loop_exit_ctl, bus.bead_vtl_ctl,
          bus.bead_trap_ctl, bus.collection_ctl, bus.waste_ctl,
          bus.dead_end_ctl, bus.pump1, bus.pump2, bus.pump3} = r_valves;

endmodule
